// File: rtl/spi_phy_soak_test.sv
// SPI PHY soak fixture: streams LFSR words through spi_phy over a registered
// loopback and keeps a running verdict, error count and word count.

module spi_phy #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_rd,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_rdy,
  output logic             o_bsy,
  output logic             o_sclk,
  output logic             o_cs_n,
  output logic             o_copi,
  input  logic             i_cipo
);
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] tx_sr;
  logic [WIDTH-2:0] rx_sr;
  logic [BW-1:0]    bit_cnt;
  logic [1:0]       phase;

  assign o_copi = tx_sr[WIDTH-1];

  // Each bit spans four clocks; CIPO is sampled at the end of the bit so the
  // one-clock loopback register has settled well before it is used.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tx_sr   <= '0;
      rx_sr   <= '0;
      bit_cnt <= '0;
      phase   <= '0;
      o_rdata <= '0;
      o_rdy   <= 1'b0;
      o_bsy   <= 1'b0;
      o_sclk  <= 1'b0;
      o_cs_n  <= 1'b1;
    end else begin
      if (i_rd) o_rdy <= 1'b0;
      if (o_bsy) begin
        phase <= phase + 2'd1;
        if (phase == 2'd1) o_sclk <= 1'b1;
        if (phase == 2'd3) begin
          o_sclk <= 1'b0;
          rx_sr  <= {rx_sr[WIDTH-3:0], i_cipo};
          if (bit_cnt == '0) begin
            o_bsy   <= 1'b0;
            o_cs_n  <= 1'b1;
            o_rdy   <= 1'b1;
            o_rdata <= {rx_sr, i_cipo};
            tx_sr   <= '0;
          end else begin
            bit_cnt <= bit_cnt - BW'(1);
            tx_sr   <= {tx_sr[WIDTH-2:0], 1'b0};
          end
        end
      end else if (i_wr) begin
        o_bsy   <= 1'b1;
        o_cs_n  <= 1'b0;
        o_rdy   <= 1'b0;
        tx_sr   <= i_wdata;
        bit_cnt <= BW'(WIDTH - 1);
        phase   <= '0;
      end
    end
  end
endmodule

// state      | meaning
// S_IDLE     | waiting for a rising edge on i_run
// S_WRITE    | phy_wr high for this one cycle
// S_WAIT_BSY | transfer in flight, waiting for busy low and ready high
// S_WAIT_RDY | busy dropped before ready rose
// S_CHECK    | phy_rd high, received word compared
// S_DONE     | verdict held until i_run drops
module spi_phy_soak_test #(
  parameter int          WIDTH   = 8,
  parameter int          N_WORDS = 16,
  parameter logic [31:0] SEED    = 32'h1,
  parameter bit          INVERT  = 1'b1,
  parameter int          TIMEOUT = 1023,
  parameter int          FAULT   = 0   // 0 none, 1 CIPO stuck low, 2 ready masked
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_run,
  output logic        o_running,
  output logic        o_passed,
  output logic [15:0] o_errors,
  output logic [15:0] o_count
);
  function automatic logic [31:0] lfsr_mask(input int w);
    case (w)
      4:       lfsr_mask = 32'h0000_000C;
      5:       lfsr_mask = 32'h0000_0014;
      6:       lfsr_mask = 32'h0000_0030;
      7:       lfsr_mask = 32'h0000_0060;
      8:       lfsr_mask = 32'h0000_00B8;
      9:       lfsr_mask = 32'h0000_0110;
      10:      lfsr_mask = 32'h0000_0240;
      11:      lfsr_mask = 32'h0000_0500;
      12:      lfsr_mask = 32'h0000_0829;
      13:      lfsr_mask = 32'h0000_100D;
      14:      lfsr_mask = 32'h0000_2015;
      15:      lfsr_mask = 32'h0000_6000;
      16:      lfsr_mask = 32'h0000_D008;
      17:      lfsr_mask = 32'h0001_2000;
      18:      lfsr_mask = 32'h0002_0400;
      19:      lfsr_mask = 32'h0004_0023;
      20:      lfsr_mask = 32'h0009_0000;
      21:      lfsr_mask = 32'h0014_0000;
      22:      lfsr_mask = 32'h0030_0000;
      23:      lfsr_mask = 32'h0042_0000;
      24:      lfsr_mask = 32'h00E1_0000;
      25:      lfsr_mask = 32'h0120_0000;
      26:      lfsr_mask = 32'h0200_0023;
      27:      lfsr_mask = 32'h0400_0013;
      28:      lfsr_mask = 32'h0900_0000;
      29:      lfsr_mask = 32'h1400_0000;
      30:      lfsr_mask = 32'h2000_0029;
      31:      lfsr_mask = 32'h4800_0000;
      32:      lfsr_mask = 32'h8020_0003;
      default: lfsr_mask = 32'h0000_000C;
    endcase
  endfunction

  localparam logic [WIDTH-1:0] TAPS       = WIDTH'(lfsr_mask(WIDTH));
  localparam logic [WIDTH-1:0] SEED_TRUNC = WIDTH'(SEED);
  localparam logic [WIDTH-1:0] SEED_W     = (SEED_TRUNC == '0) ? WIDTH'(1) : SEED_TRUNC;
  localparam int               WW         = $clog2(TIMEOUT + 2);
  localparam logic [WW-1:0]    TO         = WW'(TIMEOUT);
  localparam int               EW         = $clog2(WIDTH + 1) + 1;
  localparam logic [EW-1:0]    EDGES      = EW'(WIDTH);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_WAIT_BSY, S_WAIT_RDY, S_CHECK, S_DONE
  } state_t;

  state_t           state;
  logic             run_q;
  logic [WIDTH-1:0] lfsr;
  logic [WIDTH-1:0] lfsr_next;
  logic [WIDTH-1:0] expected;
  logic [WW-1:0]    wait_cnt;
  logic [WW-1:0]    wait_inc;
  logic             timed_out;
  logic             mismatch;
  logic             last_word;

  logic             phy_wr;
  logic             phy_rd;
  logic [WIDTH-1:0] phy_rdata;
  logic             phy_rdy_raw;
  logic             phy_rdy;
  logic             phy_bsy;
  logic             phy_sclk;
  logic             phy_cs_n;
  logic             phy_copi;
  logic             phy_cipo;
  logic             sclk_q;
  logic [EW-1:0]    sclk_edges;

  spi_phy #(.WIDTH(WIDTH)) u_phy (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_wr    (phy_wr),
    .i_wdata (lfsr),
    .i_rd    (phy_rd),
    .o_rdata (phy_rdata),
    .o_rdy   (phy_rdy_raw),
    .o_bsy   (phy_bsy),
    .o_sclk  (phy_sclk),
    .o_cs_n  (phy_cs_n),
    .o_copi  (phy_copi),
    .i_cipo  (phy_cipo)
  );

  assign phy_rdy   = phy_rdy_raw && (FAULT != 2);
  assign expected  = lfsr ^ {WIDTH{INVERT}};
  assign lfsr_next = lfsr[0] ? ((lfsr >> 1) ^ TAPS) : (lfsr >> 1);
  assign timed_out = wait_cnt > TO;
  assign wait_inc  = timed_out ? wait_cnt : wait_cnt + WW'(1);
  assign last_word = ({1'b0, o_count} + 17'd1) == 17'(N_WORDS);
  // A frame with the wrong number of SCLK pulses is a failure even if the data happens to match.
  assign mismatch  = (phy_rdata != expected) || (sclk_edges != EDGES);

  always_ff @(posedge i_clk) begin
    if (i_rst) phy_cipo <= 1'b0;
    else       phy_cipo <= !phy_cs_n && (phy_copi ^ INVERT) && (FAULT != 1);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sclk_q     <= 1'b0;
      sclk_edges <= '0;
    end else begin
      sclk_q <= phy_sclk;
      if (phy_wr)                                   sclk_edges <= '0;
      else if (phy_sclk && !sclk_q && !phy_cs_n)    sclk_edges <= sclk_edges + EW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    run_q <= i_run;
    if (i_rst) begin
      state     <= S_IDLE;
      o_running <= 1'b0;
      o_passed  <= 1'b1;
      o_errors  <= '0;
      o_count   <= '0;
      lfsr      <= SEED_W;
      phy_wr    <= 1'b0;
      phy_rd    <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      phy_wr   <= 1'b0;
      phy_rd   <= 1'b0;
      wait_cnt <= '0;
      case (state)
        S_IDLE: begin
          if (i_run && !run_q) begin
            state     <= S_WRITE;
            phy_wr    <= 1'b1;
            o_running <= 1'b1;
            o_passed  <= 1'b1;
            o_errors  <= '0;
            o_count   <= '0;
            lfsr      <= SEED_W;
          end
        end
        S_WRITE: state <= S_WAIT_BSY;
        S_WAIT_BSY: begin
          if (timed_out) begin
            o_passed  <= 1'b0;
            o_running <= 1'b0;
            state     <= S_DONE;
          end else if (!phy_bsy && phy_rdy) begin
            state  <= S_CHECK;
            phy_rd <= 1'b1;
          end else if (!phy_bsy) begin
            state <= S_WAIT_RDY;
          end else begin
            wait_cnt <= wait_inc;
          end
        end
        S_WAIT_RDY: begin
          if (timed_out) begin
            o_passed  <= 1'b0;
            o_running <= 1'b0;
            state     <= S_DONE;
          end else if (phy_rdy) begin
            state  <= S_CHECK;
            phy_rd <= 1'b1;
          end else begin
            wait_cnt <= wait_inc;
          end
        end
        S_CHECK: begin
          if (mismatch) begin
            o_passed <= 1'b0;
            if (o_errors != 16'hFFFF) o_errors <= o_errors + 16'd1;
          end
          o_count <= o_count + 16'd1;
          lfsr    <= lfsr_next;
          if (last_word) begin
            state     <= S_DONE;
            o_running <= 1'b0;
          end else begin
            state  <= S_WRITE;
            phy_wr <= 1'b1;
          end
        end
        S_DONE: if (!i_run) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/spi_phy_soak_test.md
# spi_phy_soak_test

Self-checking soak fixture for the SPI physical layer (`spi_phy`), the parametrised successor to the fixed-script SPI PHY test. It instantiates one `spi_phy` of width `WIDTH` and closes its bus through an internal loopback model. It then streams `N_WORDS` LFSR-generated words through the full write/transfer/read handshake and checks every received word against the expected loopback value. It reports pass/fail, error count and progress, and sits beside the other self-test fixtures driven by the board-level test runner.

## Interface
- `WIDTH`, 8: SPI word width in bits (4..32).
- `N_WORDS`, 16: number of words per run (1..65535).
- `SEED`, `'h1`: non-zero LFSR seed, truncated to `WIDTH` bits; 0 is replaced by 1.
- `INVERT`, 1: loopback mode. 1 drives CIPO from inverted COPI; 0 drives it from COPI unchanged.
- `TIMEOUT`, 1023: maximum clocks allowed in any wait state before the run fails.
- `i_clk`, in, 1: system clock; sole clock.
- `i_rst`, in, 1: synchronous, active-high reset.
- `i_run`, in, 1: level; a rising edge sampled in IDLE starts a run.
- `o_running`, out, 1: a run is in progress.
- `o_passed`, out, 1: the final or current verdict, valid once `o_running` falls.
- `o_errors`, out, 16: count of data mismatches; saturates at 16'hFFFF.
- `o_count`, out, 16: number of words completed (checked) in this run.

## Operation
- **UUT handshake** (`spi_phy` contract):
  - A one-cycle `i_wr` pulse with `i_wdata` while `o_bsy` is 0 starts a full-duplex transfer.
  - `o_rdy` rises when the received word is valid on `o_rdata`.
  - A one-cycle `i_rd` pulse consumes that word.
- **Loopback:** CIPO is registered each clock as `!cs && (COPI ^ INVERT)`. It is 0 while CS is deasserted.
- **Data:** a Galois LFSR of `WIDTH` bits (maximal-length taps per width) produces `wdata`. It advances once per word, after the write.
- **Expected value:** `wdata ^ {WIDTH{INVERT}}`. Example: `WIDTH`=8, `INVERT`=1, wdata 8'h9B gives expected 8'h64.
- **FSM states:** IDLE, WRITE, WAIT_BSY, WAIT_RDY, CHECK, DONE.
  - IDLE → WRITE on a rising edge of `i_run`. On entry, `o_count`=0, `o_errors`=0, `o_passed`=1, LFSR=seed.
  - WRITE: pulse `i_wr` for exactly one cycle, then go to WAIT_BSY.
  - WAIT_BSY: wait for `o_bsy`=0 and `o_rdy`=1, then go to CHECK.
  - CHECK: compare `o_rdata` with the expected value.
    - On a mismatch, increment `o_errors` and clear `o_passed`; the run continues.
    - Pulse `i_rd`, increment `o_count`, and step the LFSR.
    - Go to WRITE, or to DONE when `o_count`+1 == `N_WORDS`.
  - Timeout: if the per-state wait counter exceeds `TIMEOUT`, clear `o_passed` and go to DONE. `o_count` then shows the word that stalled.
  - DONE → IDLE when `i_run` is low. A fresh rising edge is required to rerun.
- `o_running` is 1 in every state except IDLE and DONE.
- **Reset:**
  - The FSM goes to IDLE with `o_running`=0, `o_passed`=1, `o_errors`=0, `o_count`=0, and LFSR=seed.
  - `i_wr` and `i_rd` go to 0. The `spi_phy` instance receives the same reset.
  - A reset mid-run aborts the run immediately with no verdict. Outputs show reset values.

## Timing
- `i_wr` and `i_rd` are registered. Each is high for exactly one cycle per word and never high simultaneously.
- The WAIT_RDY state exists only to keep the encoding stable. It is entered from WAIT_BSY if `o_rdy` has not yet risen while `o_bsy` is 0.
- The CHECK decision uses `o_rdata` sampled in the same cycle that `i_rd` is pulsed.
- WRITE follows CHECK on the next cycle, so back-to-back words have zero idle cycles on the fixture side.
- The wait counter clears on every state change and saturates at `TIMEOUT`+1.
- `o_count`/`o_errors` update on the CHECK clock edge. `o_running` falls on the edge that enters DONE.
- Simultaneous `i_rst` and `i_run` edge: reset wins and no run starts.

## Test plan
- Defaults, `i_run` held high → `o_running` for 16 words; it then falls with `o_passed`=1, `o_errors`=0, `o_count`=16.
- `WIDTH`=8, `SEED`=8'h9B, `INVERT`=1, `N_WORDS`=1 → the first CHECK sees `o_rdata`=8'h64; pass.
- Loopback fault injected (CIPO forced 0) with `INVERT`=1, `N_WORDS`=4 → `o_passed`=0, `o_errors`=4, `o_count`=4; the run completes.
- UUT `o_rdy` forced 0, `TIMEOUT`=15 → the run ends within 20 clocks of the first write with `o_passed`=0 and `o_count`=0.
- `i_rst` pulsed during word 3 → next cycle `o_running`=0, `o_count`=0, `o_passed`=1. A new `i_run` edge then reruns and passes.
- `WIDTH`=16, `INVERT`=0, `N_WORDS`=300 → pass; `o_count`=300; `o_errors` confirms no saturation artefacts (still 0).
